grey_decode: RTL and testbench

GREY_DECODE -- requirements
Module: grey_decode

---
 rtl/grey_decode_if.sv | 25 ++
 rtl/grey_decode.sv | 164 ++++++++++++++++
 tb/tb_grey_decode.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/grey_decode_if.sv
// Digit stream, display select and decoded-frame outputs for grey_decode.
// The master modport drives digits and SEL; the slave modport is the decoder.
interface grey_decode_if #(parameter int DIGITS = 12);
  logic [4:0]          dig_in;
  logic                dig_valid;
  logic                sof;
  logic                dig_rdy;
  logic [3:0]          sel;
  logic [4*DIGITS-1:0] value;
  logic                value_valid;
  logic                dig_err;
  logic                frm_err;
  logic                step_err;
  logic [7:0]          disp;

  modport master (
    output dig_in, dig_valid, sof, sel,
    input  dig_rdy, value, value_valid, dig_err, frm_err, step_err, disp
  );

  modport slave (
    input  dig_in, dig_valid, sof, sel,
    output dig_rdy, value, value_valid, dig_err, frm_err, step_err, disp
  );
endinterface

// File: rtl/grey_decode.sv
// Gray-coded digit stream to packed-BCD frame decoder with digit/frame error flags.
// Optional GREY_STEP_CHECK_EN adds a previous-frame register and a +1 step check.
//
// state | meaning
// IDLE  | waiting for a SOF digit; non-SOF digits are consumed and dropped
// RECV  | collecting digits 1..DIGITS-1; SOF here restarts the frame
// CHECK | one cycle to prepare the step reference (PREV+1)
// OUT   | one cycle; outputs register on the edge leaving this state
module grey_decode #(
  parameter int DIGITS = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  grey_decode_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RECV, CHECK, OUT} state_t;

  localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

  state_t              state, state_nxt;
  logic [3:0]          idx;
  logic [4*DIGITS-1:0] frame;
  logic [4*DIGITS-1:0] value_r;
  logic                frame_err;
  logic                value_valid_r;
  logic                dig_err_r;
  logic                frm_err_r;
  logic                xfer;
  logic [4:0]          bin;
  logic                bad;
  logic [3:0]          bcd;

  assign xfer = bus.dig_valid & bus.dig_rdy;

  assign bin = {bus.dig_in[4], ^bus.dig_in[4:3], ^bus.dig_in[4:2],
                ^bus.dig_in[4:1], ^bus.dig_in[4:0]};
  assign bad = (bin > 5'd9);
  assign bcd = bad ? 4'hF : bin[3:0];

  assign bus.dig_rdy = (state == IDLE) || (state == RECV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && bus.sof) state_nxt = RECV;
      RECV:    if (xfer && !bus.sof && idx == LAST_IDX) state_nxt = CHECK;
      CHECK:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // dig_err holds until the next frame completes, so it also serves as the sticky flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= 4'd0;
      frame         <= '0;
      frame_err     <= 1'b0;
      value_r       <= '0;
      value_valid_r <= 1'b0;
      dig_err_r     <= 1'b0;
      frm_err_r     <= 1'b0;
    end else begin
      value_valid_r <= 1'b0;
      frm_err_r     <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer && bus.sof) begin
            frame[3:0] <= bcd;
            frame_err  <= bad;
            idx        <= 4'd1;
          end
        end
        RECV: begin
          if (xfer) begin
            if (bus.sof) begin
              frame[3:0] <= bcd;
              frame_err  <= bad;
              idx        <= 4'd1;
              frm_err_r  <= 1'b1;
            end else begin
              for (int d = 1; d < DIGITS; d++)
                if (idx == 4'(d)) frame[4*d +: 4] <= bcd;
              frame_err <= frame_err | bad;
              idx       <= idx + 4'd1;
            end
          end
        end
        OUT: begin
          value_r       <= frame;
          value_valid_r <= 1'b1;
          dig_err_r     <= frame_err;
          idx           <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.value       = value_r;
  assign bus.value_valid = value_valid_r;
  assign bus.dig_err     = dig_err_r;
  assign bus.frm_err     = frm_err_r;

  always_comb begin
    bus.disp = 8'h00;
    for (int d = 0; d < DIGITS; d++)
      if (bus.sel == 4'(d)) bus.disp = {dig_err_r, 3'b000, value_r[4*d +: 4]};
  end

`ifdef GREY_STEP_CHECK_EN
  logic [4*DIGITS-1:0] prev;
  logic [4*DIGITS-1:0] inc_r;
  logic [4*DIGITS-1:0] inc_nxt;
  logic                prev_vld;
  logic                step_r;

  // BCD increment with ripple carry; all-nines wraps to zero
  always_comb begin
    logic carry;
    carry   = 1'b1;
    inc_nxt = prev;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (prev[4*d +: 4] == 4'd9) begin
          inc_nxt[4*d +: 4] = 4'd0;
        end else begin
          inc_nxt[4*d +: 4] = prev[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      inc_r    <= '0;
      prev_vld <= 1'b0;
      step_r   <= 1'b0;
    end else begin
      if (state == CHECK) inc_r <= inc_nxt;
      if (state == OUT) begin
        step_r <= !frame_err && prev_vld && (frame != inc_r);
        if (!frame_err) begin
          prev     <= frame;
          prev_vld <= 1'b1;
        end
      end
    end
  end

  assign bus.step_err = step_r;
`else
  assign bus.step_err = 1'b0;
`endif

endmodule

// File: tb/tb_grey_decode.sv
// Directed bench for grey_decode: vector table of whole frames plus
// restart, mid-frame reset and latency sequences.
module tb_grey_decode;
  localparam int DIGITS = 12;

  typedef struct {
    logic [59:0] gray;
    logic [47:0] value;
    logic        err;
    logic        step;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   vv_cnt = 0;
  vec_t vecs[10];

  grey_decode_if #(.DIGITS(DIGITS)) bus();
  grey_decode #(.DIGITS(DIGITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.value_valid) vv_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [59:0] gframe(input logic [47:0] bcd);
    logic [4:0] b;
    gframe = '0;
    for (int d = 0; d < 12; d++) begin
      b = {1'b0, bcd[4*d +: 4]};
      gframe[5*d +: 5] = b ^ (b >> 1);
    end
  endfunction

  function automatic logic exp_step(input logic s);
`ifdef GREY_STEP_CHECK_EN
    return s;
`else
    return 1'b0;
`endif
  endfunction

  // One digit transfer; returns #1 after the accepting edge
  task automatic xfer(input logic [4:0] g, input logic s);
    int n = 0;
    bus.dig_in    = g;
    bus.sof       = s;
    bus.dig_valid = 1'b1;
    @(negedge clk);
    while (!bus.dig_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: got dig_rdy 0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.dig_valid = 1'b0;
    bus.sof       = 1'b0;
  endtask

  task automatic send_frame(input logic [59:0] g);
    for (int i = 0; i < DIGITS; i++) xfer(g[5*i +: 5], i == 0);
  endtask

  // Called #1 after the edge that accepted the last digit
  task automatic expect_frame(input string name, input logic [47:0] val,
                              input logic err, input logic step);
    logic [7:0] d;
    int sels[4] = '{0, 11, 12, 15};
    check({name, "_rdy_check"}, bus.dig_rdy, 0);
    @(posedge clk); #1;
    check({name, "_vv_early"}, bus.value_valid, 0);
    check({name, "_rdy_out"}, bus.dig_rdy, 0);
    @(posedge clk); #1;
    check({name, "_vv"}, bus.value_valid, 1);
    check({name, "_value"}, bus.value, val);
    check({name, "_dig_err"}, bus.dig_err, err);
    check({name, "_step_err"}, bus.step_err, exp_step(step));
    for (int k = 0; k < 4; k++) begin
      bus.sel = 4'(sels[k]);
      #1;
      d = (sels[k] < DIGITS) ? {err, 3'b000, val[4*sels[k] +: 4]} : 8'h00;
      check($sformatf("%s_disp_sel%0d", name, sels[k]), bus.disp, d);
    end
    bus.sel = 4'd0;
    @(posedge clk); #1;
    check({name, "_vv_pulse"}, bus.value_valid, 0);
  endtask

  initial begin
    logic [59:0] g;
    int vv_before;

    vecs[0] = '{60'h00D, 48'h000000000009, 1'b0, 1'b0};
    vecs[1] = '{60'h00F, 48'h00000000000F, 1'b1, 1'b0};
    vecs[2] = '{gframe(48'h123456789012), 48'h123456789012, 1'b0, 1'b1};
    vecs[3] = '{gframe(48'h000000000999), 48'h000000000999, 1'b0, 1'b1};
    vecs[4] = '{gframe(48'h000000001000), 48'h000000001000, 1'b0, 1'b0};
    vecs[5] = '{gframe(48'h000000001002), 48'h000000001002, 1'b0, 1'b1};
    vecs[6] = '{gframe(48'h999999999999), 48'h999999999999, 1'b0, 1'b1};
    vecs[7] = '{gframe(48'h000000000000), 48'h000000000000, 1'b0, 1'b0};
    vecs[8] = '{60'hF80000000000000, 48'hF00000000000, 1'b1, 1'b0};
    vecs[9] = '{gframe(48'h000000000001), 48'h000000000001, 1'b0, 1'b0};

    bus.dig_in = 5'd0; bus.dig_valid = 1'b0; bus.sof = 1'b0; bus.sel = 4'd0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_rdy", bus.dig_rdy, 1);
    check("rst_value", bus.value, 0);
    check("rst_vv", bus.value_valid, 0);
    check("rst_dig_err", bus.dig_err, 0);
    check("rst_frm_err", bus.frm_err, 0);
    check("rst_step_err", bus.step_err, 0);
    check("rst_disp", bus.disp, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].gray);
      expect_frame($sformatf("vec%0d", i), vecs[i].value, vecs[i].err, vecs[i].step);
    end

    // SOF at digit 5 aborts the partial frame and restarts
    vv_before = vv_cnt;
    g = gframe(48'h000000000777);
    for (int i = 0; i < 5; i++) xfer(g[5*i +: 5], i == 0);
    check("restart_frm_err_idle", bus.frm_err, 0);
    g = gframe(48'h000000000002);
    xfer(g[4:0], 1'b1);
    check("restart_frm_err_pulse", bus.frm_err, 1);
    xfer(g[9:5], 1'b0);
    check("restart_frm_err_clear", bus.frm_err, 0);
    for (int i = 2; i < DIGITS; i++) xfer(g[5*i +: 5], 1'b0);
    expect_frame("restart", 48'h000000000002, 1'b0, 1'b0);
    check("restart_vv_count", vv_cnt, vv_before + 1);

    // Reset after digit 7 of a frame
    g = gframe(48'h555555555555);
    for (int i = 0; i < 8; i++) xfer(g[5*i +: 5], i == 0);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_value", bus.value, 0);
    check("midrst_vv", bus.value_valid, 0);
    check("midrst_dig_err", bus.dig_err, 0);
    check("midrst_frm_err", bus.frm_err, 0);
    check("midrst_step_err", bus.step_err, 0);
    check("midrst_disp", bus.disp, 0);
    check("midrst_rdy", bus.dig_rdy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    vv_before = vv_cnt;
    for (int i = 8; i < DIGITS; i++) xfer(g[5*i +: 5], 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_vv", vv_cnt, vv_before);
    check("midrst_value_hold", bus.value, 0);
    send_frame(gframe(48'h000000000005));
    expect_frame("postrst", 48'h000000000005, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
